// File: rtl/spi_log_pkg.sv
// Shared types and constants for the SPI sniffer log arbiter.
package spi_log_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        TAG_WAIT,
        DATA,
        DATA_WAIT
    } state_t;

    // Channel index: 0 = ch0, 1 = ch1
    typedef logic ch_t;

    localparam logic [7:0] DEFAULT_TAG0 = 8'hA0;
    localparam logic [7:0] DEFAULT_TAG1 = 8'hA1;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with a first-word-fall-through read port.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // Full comes from the registered count, so a write while full is refused
    // even if a pop happens in the same cycle.
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_log_arbiter.sv
// Merges two sniffer byte streams onto one UART, inserting a channel tag
// whenever the source channel changes and bounding bursts from one channel.
module spi_log_arbiter
    import spi_log_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         MAX_BURST  = 8,
    parameter logic [7:0] TAG0       = DEFAULT_TAG0,
    parameter logic [7:0] TAG1       = DEFAULT_TAG1
) (
    input  logic       fifo_clk,
    input  logic       reset,
    input  logic [7:0] ch0_data,
    input  logic [7:0] ch1_data,
    input  logic       ch0_valid,
    input  logic       ch1_valid,
    input  logic       uart_busy,
    output logic [7:0] uart_data,
    output logic       uart_start,
    output logic [1:0] overflow,
    output logic       idle
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    state_t        r_state;
    state_t        w_state_nxt;
    ch_t           r_sel;
    ch_t           w_sel_nxt;
    ch_t           r_last_ch;
    logic          r_last_vld;
    logic [BW-1:0] r_burst;
    logic          r_guard;
    logic [7:0]    r_byte;
    logic [7:0]    r_uart_data;
    logic [1:0]    r_overflow;

    logic [1:0]    w_empty;
    logic [1:0]    w_full;
    logic [1:0]    w_rd_en;
    logic [7:0]    w_rd_data0;
    logic [7:0]    w_rd_data1;
    logic          w_pop;
    logic          w_start;
    logic          w_fire;
    ch_t           w_cur;
    ch_t           w_oth;
    logic [7:0]    w_tx_byte;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk     (fifo_clk),
        .reset   (reset),
        .wr_en   (ch0_valid),
        .wr_data (ch0_data),
        .rd_en   (w_rd_en[0]),
        .rd_data (w_rd_data0),
        .empty   (w_empty[0]),
        .full    (w_full[0])
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk     (fifo_clk),
        .reset   (reset),
        .wr_en   (ch1_valid),
        .wr_data (ch1_data),
        .rd_en   (w_rd_en[1]),
        .rd_data (w_rd_data1),
        .empty   (w_empty[1]),
        .full    (w_full[1])
    );

    // Before any tag has gone out, last_ch holds its reset value (ch0) and
    // acts as the "current" channel for selection only.
    assign w_cur = r_last_ch;
    assign w_oth = ~r_last_ch;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_pop       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_empty != 2'b11) begin
                    if (!w_empty[w_cur] && (r_burst < BURST_MAX)) w_sel_nxt = w_cur;
                    else if (!w_empty[w_oth])                     w_sel_nxt = w_oth;
                    else                                          w_sel_nxt = w_cur;
                    if (!r_last_vld || (w_sel_nxt != r_last_ch)) begin
                        w_state_nxt = TAG;
                    end else begin
                        w_state_nxt = DATA;
                        w_pop       = 1'b1;
                    end
                end
            end
            TAG: begin
                if (!uart_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = TAG_WAIT;
                end
            end
            DATA: begin
                if (!uart_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = DATA_WAIT;
                end
            end
            TAG_WAIT: begin
                if (!r_guard && !uart_busy) begin
                    w_state_nxt = DATA;
                    w_pop       = 1'b1;
                end
            end
            DATA_WAIT: begin
                if (!r_guard && !uart_busy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rd_en[0] = w_pop && (w_sel_nxt == 1'b0);
    assign w_rd_en[1] = w_pop && (w_sel_nxt == 1'b1);
    assign w_fire     = w_start && !reset;
    assign w_tx_byte  = (r_state == TAG) ? (r_sel ? TAG1 : TAG0) : r_byte;

    assign uart_start = w_fire;
    assign uart_data  = w_fire ? w_tx_byte : r_uart_data;
    assign overflow   = r_overflow;
    assign idle       = (r_state == IDLE) && (w_empty == 2'b11);

    always_ff @(posedge fifo_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sel       <= 1'b0;
            r_last_ch   <= 1'b0;
            r_last_vld  <= 1'b0;
            r_burst     <= '0;
            r_guard     <= 1'b0;
            r_uart_data <= 8'h00;
            r_overflow  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            // Blinds the first WAIT cycle, before the UART has raised busy.
            r_guard <= w_fire;
            if (w_fire) r_uart_data <= w_tx_byte;
            if (w_fire && (r_state == TAG)) begin
                r_last_ch  <= r_sel;
                r_last_vld <= 1'b1;
                r_burst    <= '0;
            end
            if (w_fire && (r_state == DATA) && (r_burst != BURST_MAX)) begin
                r_burst <= r_burst + 1'b1;
            end
            if (ch0_valid && w_full[0]) r_overflow[0] <= 1'b1;
            if (ch1_valid && w_full[1]) r_overflow[1] <= 1'b1;
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (w_pop) r_byte <= w_sel_nxt ? w_rd_data1 : w_rd_data0;
    end

endmodule

// File: tb/tb_spi_log_arbiter.sv
// Directed bench for spi_log_arbiter: vector table plus multi-cycle corner sequences.
module tb_spi_log_arbiter;

    logic       fifo_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ch0_data = 8'h00;
    logic [7:0] ch1_data = 8'h00;
    logic       ch0_valid = 1'b0;
    logic       ch1_valid = 1'b0;
    logic       uart_busy;
    logic [7:0] uart_data;
    logic       uart_start;
    logic [1:0] overflow;
    logic       idle;

    spi_log_arbiter dut (
        .fifo_clk   (fifo_clk),
        .reset      (reset),
        .ch0_data   (ch0_data),
        .ch1_data   (ch1_data),
        .ch0_valid  (ch0_valid),
        .ch1_valid  (ch1_valid),
        .uart_busy  (uart_busy),
        .uart_data  (uart_data),
        .uart_start (uart_start),
        .overflow   (overflow),
        .idle       (idle)
    );

    always #5 fifo_clk = ~fifo_clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;
    int         n_starts = 0;
    int         last_start_cyc = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    // UART model: busy for three cycles after each start request.
    assign uart_busy = force_busy || (busy_cnt != 0);

    always @(posedge fifo_clk) begin
        cyc <= cyc + 1;
        if (uart_start)         busy_cnt <= 3;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge fifo_clk) begin
        if (uart_start) begin
            got.push_back(uart_data);
            n_starts++;
            last_start_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  c0v;
        logic [15:0] c0d;
        logic [1:0]  c1v;
        logic [15:0] c1d;
        int          n;
        logic [47:0] exp;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    task automatic step();
        @(posedge fifo_clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        got.delete();
        n_starts = 0;
    endtask

    task automatic strobe(logic v0, logic [7:0] d0, logic v1, logic [7:0] d1);
        ch0_valid = v0;
        ch0_data  = d0;
        ch1_valid = v1;
        ch1_data  = d1;
        step();
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int k;
        k = 0;
        while ((idle !== 1'b1) && (k < 2000)) begin
            step();
            k++;
        end
        check({name, " idle_reached"}, (k < 2000), 1);
        repeat (5) step();
    endtask

    task automatic check_seq(string name);
        check({name, " byte_count"}, got.size(), exp_q.size());
        for (int i = 0; (i < exp_q.size()) && (i < got.size()); i++) begin
            check($sformatf("%s byte%0d", name, i), got[i], exp_q[i]);
        end
    endtask

    initial begin
        int c0;
        int k;
        int nst;

        vecs[0] = '{2'b11, 16'h1122, 2'b00, 16'h0000, 3, {8'hA0, 8'h11, 8'h22, 24'h0}};
        vecs[1] = '{2'b10, 16'h3300, 2'b10, 16'h4400, 4, {8'hA0, 8'h33, 8'hA1, 8'h44, 16'h0}};
        vecs[2] = '{2'b00, 16'h0000, 2'b10, 16'h7700, 2, {8'hA1, 8'h77, 32'h0}};
        vecs[3] = '{2'b01, 16'h006B, 2'b10, 16'h5A00, 4, {8'hA1, 8'h5A, 8'hA0, 8'h6B, 16'h0}};
        vecs[4] = '{2'b11, 16'h00FF, 2'b00, 16'h0000, 3, {8'hA0, 8'h00, 8'hFF, 24'h0}};
        vecs[5] = '{2'b11, 16'h0102, 2'b11, 16'h0304, 6, {8'hA0, 8'h01, 8'h02, 8'hA1, 8'h03, 8'h04}};

        // Reset values, sampled while reset is still held
        reset = 1'b1;
        step();
        step();
        check("reset uart_start", uart_start, 0);
        check("reset uart_data", uart_data, 8'h00);
        check("reset overflow", overflow, 2'b00);
        check("reset idle", idle, 1);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            do_reset();
            for (int s = 0; s < 2; s++) begin
                strobe(vecs[v].c0v[1-s], vecs[v].c0d[15-8*s -: 8],
                       vecs[v].c1v[1-s], vecs[v].c1d[15-8*s -: 8]);
            end
            wait_idle($sformatf("vec%0d", v));
            exp_q.delete();
            for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].exp[47-8*i -: 8]);
            check_seq($sformatf("vec%0d", v));
            check($sformatf("vec%0d overflow", v), overflow, 2'b00);
        end

        // Latency with last_ch already ch0: start two cycles after the strobe, no tag
        do_reset();
        strobe(1'b1, 8'h11, 1'b0, 8'h00);
        wait_idle("lat_setup");
        nst = n_starts;
        k = got.size();
        ch0_valid = 1'b1;
        ch0_data  = 8'h66;
        c0 = cyc;
        step();
        ch0_valid = 1'b0;
        step();
        @(negedge fifo_clk);
        #1;
        check("lat start_count", n_starts, nst + 1);
        check("lat cycles", last_start_cyc - c0, 2);
        check("lat no_tag byte", got[k], 8'h66);
        wait_idle("lat_tail");
        check("lat total_bytes", got.size(), k + 1);

        // Overflow with UART stalled: 17 strobes into a 16-deep FIFO
        force_busy = 1'b1;
        do_reset();
        for (int i = 0; i < 17; i++) strobe(1'b1, 8'(8'h80 + i), 1'b0, 8'h00);
        repeat (3) step();
        check("ovf flag", overflow, 2'b01);
        check("ovf no_start", n_starts, 0);
        force_busy = 1'b0;
        wait_idle("ovf");
        exp_q.delete();
        exp_q.push_back(8'hA0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h80 + i));
        check_seq("ovf");
        check("ovf sticky", overflow, 2'b01);

        // Burst limit: 12 ch1 bytes against 2 waiting ch0 bytes
        force_busy = 1'b1;
        do_reset();
        strobe(1'b0, 8'h00, 1'b1, 8'hC0);
        for (int i = 1; i < 12; i++) begin
            strobe((i < 3), 8'(8'hD0 + i - 1), 1'b1, 8'(8'hC0 + i));
        end
        force_busy = 1'b0;
        wait_idle("burst");
        exp_q.delete();
        exp_q.push_back(8'hA1);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'hC0 + i));
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'hD1);
        exp_q.push_back(8'hA1);
        for (int i = 8; i < 12; i++) exp_q.push_back(8'(8'hC0 + i));
        check_seq("burst");

        // Reset while in DATA_WAIT with three bytes still queued
        do_reset();
        for (int i = 0; i < 4; i++) strobe(1'b1, 8'(8'h10 * (i + 1)), 1'b0, 8'h00);
        k = 0;
        while ((n_starts < 2) && (k < 200)) begin
            step();
            k++;
        end
        check("rst_wait second_start", (k < 200), 1);
        exp_q.delete();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h10);
        check_seq("rst_pre");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst idle_after", idle, 1);
        got.delete();
        nst = n_starts;
        repeat (8) step();
        check("rst no_start", n_starts, nst);
        check("rst fifos_empty", idle, 1);
        strobe(1'b1, 8'h55, 1'b0, 8'h00);
        wait_idle("rst_post");
        exp_q.delete();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h55);
        check_seq("rst_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_log_arbiter.md
SPI_LOG_ARBITER -- requirements
Module: spi_log_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, bytes buffered per channel (power of two, 4..64).
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum consecutive data bytes sent from one channel while the other channel is waiting.
REQ-003 SHALL have parameter TAG0, default 8'hA0, channel-0 header byte.
REQ-004 SHALL have parameter TAG1, default 8'hA1, channel-1 header byte.
REQ-005 SHALL have port fifo_clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports ch0_data and ch1_data, input, 8 each: captured bytes from the two sniffer channels.
REQ-008 SHALL have ports ch0_valid and ch1_valid, input, 1 each: one-cycle strobe qualifying the matching chN_data.
REQ-009 SHALL have port uart_busy, input, 1: high while the UART is transmitting.
REQ-010 SHALL have port uart_data, output, 8: byte for the UART, held stable from the uart_start pulse until the next pulse.
REQ-011 SHALL have port uart_start, output, 1: one-cycle transmit request.
REQ-012 SHALL have port overflow, output, 2: sticky per-channel byte-drop flags, bit0 = ch0.
REQ-013 SHALL have port idle, output, 1: high when both FIFOs are empty and the FSM is in IDLE.

Function
REQ-014 SHALL buffer each channel in its own FIFO; a chN_valid strobe SHALL write chN_data in that cycle.
REQ-015 SHALL evaluate full before any same-cycle pop; a valid strobe while full SHALL drop the byte and set overflow[N].
REQ-016 SHALL use FSM states IDLE, TAG, TAG_WAIT, DATA, DATA_WAIT.
REQ-017 IDLE: if any FIFO is non-empty, SHALL select a channel: the current channel while it is non-empty and its burst count is below MAX_BURST, otherwise the other channel if non-empty, otherwise the current channel.
REQ-018 On selection, SHALL go to TAG if the selected channel differs from last_ch or last_ch is invalid; otherwise SHALL go to DATA and pop one byte.
REQ-019 TAG/DATA: when uart_busy == 0, SHALL drive uart_data (TAGn or the popped byte) and pulse uart_start for exactly one cycle, then go to TAG_WAIT/DATA_WAIT.
REQ-020 *_WAIT: SHALL ignore uart_busy for the first cycle (guard), then wait for uart_busy == 0.
REQ-021 TAG_WAIT SHALL then go to DATA with a pop of the selected channel.
REQ-022 DATA_WAIT SHALL then return to IDLE.
REQ-023 After a tag, SHALL set last_ch to the selected channel and reset the burst count to 0.
REQ-024 Each data byte sent SHALL increment the burst count, saturating at MAX_BURST.
REQ-025 Latency: a byte written at cycle N to an empty FIFO, with FSM IDLE, last_ch equal to that channel and uart_busy low, SHALL produce uart_start at cycle N+2.
REQ-026 Simultaneous strobes on both channels SHALL both be accepted when neither FIFO is full.
REQ-027 Byte order within a channel SHALL be preserved; no byte SHALL be sent twice.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; each FIFO SHALL use a count of width log2(FIFO_DEPTH)+1 to distinguish full from empty.

Reset
REQ-029 While reset is high at a fifo_clk edge, SHALL set FSM to IDLE, empty both FIFOs, set last_ch invalid, clear burst count, overflow = 2'b00, uart_start = 0, uart_data = 8'h00, idle = 1.
REQ-030 Reset during *_WAIT SHALL abandon the transfer without a further uart_start; the next byte after reset SHALL be preceded by a tag.

Structure
REQ-031 Package spi_log_pkg SHALL hold the FSM state enum, default tag constants and the channel-index type.
REQ-032 Per-channel FIFO SHALL be sub-module byte_fifo (parameter DEPTH; ports wr_en, wr_data, rd_en, rd_data, empty, full), instantiated twice.

Verification
REQ-033 Reset, then ch0 bytes 8'h11 and 8'h22, uart_busy low -> UART sequence A0, 11, 22.
REQ-034 Both channels strobed same cycle with 8'h33 (ch0) and 8'h44 (ch1) -> sequence A0, 33, A1, 44.
REQ-035 12 ch1 bytes queued while ch0 also has 2 bytes, MAX_BURST=8 -> 8 ch1 bytes, A0, 2 ch0 bytes, A1, 4 ch1 bytes.
REQ-036 uart_busy held high, 17 ch0 strobes -> 16 bytes stored, overflow = 2'b01, no uart_start until busy drops.
REQ-037 Reset asserted during DATA_WAIT with 3 bytes queued -> no uart_start, FIFOs empty; a new ch0 byte 8'h55 -> A0, 55.
REQ-038 last_ch = ch0, idle FSM, ch0 strobe at cycle N -> uart_start at N+2, no tag.
